// File: rtl/dm_responder.sv
// dm_responder: data-memory responder with valid/ready request handshake,
// programmable wait states and byte-lane stores into an internal word RAM.
// Optional store/fault logging is enabled with the DM_WRITE_LOG_EN macro.
module dm_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        accept;
   logic        commit;

   logic        lat_we;
   logic [31:0] lat_addr;
   logic [3:0]  lat_be;
   logic [31:0] lat_wdata;

   logic        cur_we;
   logic [31:0] cur_addr;
   logic [3:0]  cur_be;
   logic [31:0] cur_wdata;
   logic [ADDR_WIDTH-1:0] cur_idx;
   logic        cur_oor;
   logic        cur_err;
   logic [31:0] cur_word;
   logic [31:0] merged;

   logic [31:0] mem [DEPTH];

   // Store lane pattern must be one of the legal shapes and sit on the
   // lane(s) selected by the low address bits.
   function automatic logic lane_ok(input logic [3:0] be, input logic [1:0] off);
      case (be)
         4'b0001: lane_ok = (off == 2'd0);
         4'b0010: lane_ok = (off == 2'd1);
         4'b0100: lane_ok = (off == 2'd2);
         4'b1000: lane_ok = (off == 2'd3);
         4'b0011: lane_ok = (off == 2'd0);
         4'b1100: lane_ok = (off == 2'd2);
         4'b1111: lane_ok = (off == 2'd0);
         default: lane_ok = 1'b0;
      endcase
   endfunction

   // Replace the enabled byte lanes of the stored word with the store data.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  be);
      merge_bytes = old;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) merge_bytes[8*b +: 8] = wdata[8*b +: 8];
      end
   endfunction

   assign accept = req_valid && req_ready;

   // With zero wait states the access completes on the acceptance edge, so
   // the live request is used in IDLE and the latched copy otherwise.
   assign cur_we    = (state == IDLE) ? req_we    : lat_we;
   assign cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
   assign cur_be    = (state == IDLE) ? req_be    : lat_be;
   assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;

   assign cur_idx  = cur_addr[ADDR_WIDTH+1:2];
   assign cur_oor  = |cur_addr[31:ADDR_WIDTH+2];
   assign cur_err  = cur_oor | (cur_we & ~lane_ok(cur_be, cur_addr[1:0]));
   assign cur_word = mem[cur_idx];
   assign merged   = merge_bytes(cur_word, cur_wdata, cur_be);
   assign commit   = (state_nxt == RESP);

   // State and wait-counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state, wait-counter and handshake outputs.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = ~reset;
            if (req_valid && ~reset) begin
               if (LATENCY == 0) begin
                  state_nxt = RESP;
               end else begin
                  cnt_nxt   = 4'(LATENCY - 1);
                  state_nxt = BUSY;
               end
            end
         end
         BUSY: begin
            if (cnt == 4'd0) state_nxt = RESP;
            else             cnt_nxt   = cnt - 4'd1;
         end
         RESP: begin
            resp_valid = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Capture the accepted request for the wait-state period.
   always_ff @(posedge clk) begin
      if (accept) begin
         lat_we    <= req_we;
         lat_addr  <= req_addr;
         lat_be    <= req_be;
         lat_wdata <= req_wdata;
      end
   end

   // Word RAM: cleared by reset, written only by a fault-free store on commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
      end else if (commit && cur_we && !cur_err) begin
         mem[cur_idx] <= merged;
      end
   end

   // Response data and fault flag, updated on the edge into RESP and held.
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
      end else if (commit) begin
         resp_err   <= cur_err;
         resp_rdata <= (cur_err || cur_we) ? 32'd0 : cur_word;
      end
   end

`ifdef DM_WRITE_LOG_EN
   logic [31:0] lat_pc;
   logic [31:0] cur_pc;

   assign cur_pc = (state == IDLE) ? req_pc : lat_pc;

   // Hold the issuing PC alongside the latched request.
   always_ff @(posedge clk) begin
      if (accept) lat_pc <= req_pc;
   end

   // Trace each committed store and each fault.
   always_ff @(posedge clk) begin
      if (!reset && commit) begin
         if (cur_err)
            $display("@%08h: DM fault %08h", cur_pc, cur_addr);
         else if (cur_we)
            $display("@%08h: *%08h <= %08h", cur_pc, {cur_addr[31:2], 2'b00}, merged);
      end
   end
`else
   logic unused_pc;
   assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a LATENCY=2 instance driven from a vector
// table plus reset-abort sequence, and a LATENCY=0 instance for throughput.
module tb_dm_responder;
   logic        clk = 1'b0;
   logic        reset;

   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata, req_pc;
   logic [3:0]  req_be;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;

   logic        req_valid0, req_ready0, req_we0;
   logic [31:0] req_addr0, req_wdata0, req_pc0;
   logic [3:0]  req_be0;
   logic        resp_valid0, resp_err0;
   logic [31:0] resp_rdata0;

   int n_applied = 0;
   int n_miss    = 0;

   always #5 clk = ~clk;

   dm_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_l2 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .req_pc(req_pc),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   dm_responder #(.ADDR_WIDTH(10), .LATENCY(0)) u_l0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
      .req_addr(req_addr0), .req_be(req_be0), .req_wdata(req_wdata0), .req_pc(req_pc0),
      .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vt[21];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One request on the LATENCY=2 instance; starts and ends at a negedge.
   task automatic apply(input int id, input vec_t v);
      int rdy_low;
      int lat;
      int wait_cnt;
      string tag;
      tag = $sformatf("v%0d", id);
      req_we    = v.we;
      req_addr  = v.addr;
      req_be    = v.be;
      req_wdata = v.wdata;
      req_pc    = 32'h1000 + 32'(id * 4);
      req_valid = 1'b1;
      wait_cnt  = 0;
      while (!req_ready && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      rdy_low = 0;
      lat     = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!req_ready) rdy_low++;
         if (resp_valid) begin
            lat = k;
            break;
         end
      end
      chk({tag, "_latency"}, 32'(lat), 32'd2);
      chk({tag, "_ready_low"}, 32'(rdy_low), 32'd3);
      chk({tag, "_rdata"}, resp_rdata, v.exp_rdata);
      chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, v.exp_err});
      @(negedge clk);
      chk({tag, "_strobe_drop"}, {30'd0, resp_valid, req_ready}, 32'b01);
      chk({tag, "_rdata_hold"}, resp_rdata, v.exp_rdata);
   endtask

   initial begin
      int seen;
      int i, r, last_resp;
      int acc_cyc[8];
      logic [31:0] l0_addr[8];
      logic [31:0] l0_data[8];
      vec_t v;

      vt[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
      vt[1]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 32'hDEADBEEF, 1'b0};
      vt[2]  = '{1'b1, 32'h0000_0010, 4'hF, 32'h11223344, 32'h0000_0000, 1'b0};
      vt[3]  = '{1'b1, 32'h0000_0013, 4'h8, 32'hAB000000, 32'h0000_0000, 1'b0};
      vt[4]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 32'hAB223344, 1'b0};
      vt[5]  = '{1'b1, 32'h0000_0012, 4'hC, 32'h55660000, 32'h0000_0000, 1'b0};
      vt[6]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 32'h55663344, 1'b0};
      vt[7]  = '{1'b1, 32'h0000_1000, 4'hF, 32'hCAFEF00D, 32'h0000_0000, 1'b1};
      vt[8]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vt[9]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 32'h55663344, 1'b0};
      vt[10] = '{1'b1, 32'h0000_0011, 4'h3, 32'h0000BEEF, 32'h0000_0000, 1'b1};
      vt[11] = '{1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 32'h55663344, 1'b0};
      vt[12] = '{1'b1, 32'h0000_0011, 4'h2, 32'h0000AA00, 32'h0000_0000, 1'b0};
      vt[13] = '{1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 32'h5566AA44, 1'b0};
      vt[14] = '{1'b1, 32'h0000_0011, 4'h1, 32'h000000EE, 32'h0000_0000, 1'b1};
      vt[15] = '{1'b1, 32'h0000_0012, 4'hF, 32'hFFFFFFFF, 32'h0000_0000, 1'b1};
      vt[16] = '{1'b0, 32'h8000_0010, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
      vt[17] = '{1'b1, 32'h0000_0010, 4'h5, 32'h12121212, 32'h0000_0000, 1'b1};
      vt[18] = '{1'b0, 32'h0000_0012, 4'h5, 32'h0000_0000, 32'h5566AA44, 1'b0};
      vt[19] = '{1'b1, 32'h0000_0FFC, 4'hF, 32'h01020304, 32'h0000_0000, 1'b0};
      vt[20] = '{1'b0, 32'h0000_0FFC, 4'h0, 32'h0000_0000, 32'h01020304, 1'b0};

      for (int k = 0; k < 8; k++) begin
         l0_addr[k] = 32'h40 + 32'((k % 4) * 4);
         l0_data[k] = 32'hA0A0_0000 + 32'(k + 1);
      end

      reset = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0; req_pc = '0;
      req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_be0 = '0; req_wdata0 = '0; req_pc0 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready_during", {31'd0, req_ready}, 32'd0);
      chk("rst_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", {31'd0, resp_err}, 32'd0);
      chk("rst_l0_rdata", resp_rdata0, 32'd0);
      reset = 1'b0;
      #1;
      chk("rst_ready_idle", {30'd0, req_ready, req_ready0}, 32'b11);

      for (int k = 0; k < 21; k++) apply(k, vt[k]);

      // LATENCY=0: 4 stores then 4 loads with the request held continuously.
      i = 0; r = 0; last_resp = 0;
      for (int cyc = 0; cyc < 40 && r < 8; cyc++) begin
         @(negedge clk);
         if (resp_valid0) begin
            chk($sformatf("l0_lat_%0d", r), 32'(cyc - acc_cyc[r]), 32'd1);
            if (r > 0) chk($sformatf("l0_spacing_%0d", r), 32'(cyc - last_resp), 32'd2);
            chk($sformatf("l0_rdata_%0d", r), resp_rdata0, (r < 4) ? 32'd0 : l0_data[r - 4]);
            chk($sformatf("l0_err_%0d", r), {31'd0, resp_err0}, 32'd0);
            last_resp = cyc;
            r++;
         end
         if (i < 8) begin
            req_valid0 = 1'b1;
            req_we0    = (i < 4);
            req_addr0  = l0_addr[i];
            req_be0    = 4'hF;
            req_wdata0 = l0_data[i];
            req_pc0    = 32'h2000 + 32'(i * 4);
            if (req_ready0) begin
               acc_cyc[i] = cyc;
               i++;
            end
         end else begin
            req_valid0 = 1'b0;
         end
      end
      req_valid0 = 1'b0;
      chk("l0_resp_count", 32'(r), 32'd8);

      // Reset while a store is waiting in BUSY: no response, nothing written.
      @(negedge clk);
      req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'h12345678;
      req_pc = 32'h3000; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      chk("rst_abort_no_resp", 32'(seen), 32'd0);
      v = '{1'b0, 32'h0000_0020, 4'h0, 32'h0, 32'h0000_0000, 1'b0};
      apply(100, v);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
      $finish;
   end
endmodule
